beta_dest_pipe: RTL and testbench
=================================

// Module: beta_dest_pipe
// PURPOSE
//  Producer side of the Beta bypass interface. Carries each issued instruction's destination tag
//  and result through the ALU, MEM and WB stages. Drives aP0/aP1/aP2 tags and ALUout/MEMout/WBout
//  data to every bypass unit, and performs the single register-file write at WB.
//  Sequences load completion (variable memory latency) and freezes the pipe while a load is pending.
// PARAMETERS
//  DW      32  data width
//  ZERO_R  31  register index that is never written; also the bubble address
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  id_valid     in   1   decode issues an instruction into ALU stage this cycle
//  id_rc        in   5   destination register of issued instruction
//  id_kind      in   2   00 ALU-result, 01 LD, 10 LDR, 11 no-write (ST, plain branch)
//  stall_in     in   1   OR of bypass stalls; forces bubble into ALU stage
//  flush        in   1   annul instruction being issued (taken branch)
//  alu_result   in   DW  result computed in ALU stage this cycle
//  mem_rdata    in   DW  load data
//  mem_rvalid   in   1   mem_rdata valid this cycle
//  aP0/aP1/aP2  out  7   tags of ALU/MEM/WB stage: [6]=LD pending, [5]=LDR pending, [4:0]=rc
//  ALUout       out  DW  ALU-stage result (combinational pass of alu_result)
//  MEMout       out  DW  MEM-stage registered data
//  WBout        out  DW  WB-stage registered data
//  rf_we        out  1   register-file write enable
//  rf_wa        out  5   write address
//  rf_wd        out  DW  write data
//  pipe_hold    out  1   MEM waiting on load; upstream (PC, decode) must hold
// BEHAVIOUR
//  - Reset: all stages bubble; aP0..aP2=7'h1F; MEMout=WBout=0; rf_we=0; pipe_hold=0; MEM FSM=IDLE.
//  - Bubble: rc=ZERO_R, flags 00, no write. Issued with id_kind=11 also become rc=ZERO_R.
//  - Issue: id_valid & !stall_in & !flush & !pipe_hold loads tag into ALU stage; otherwise bubble
//    (stall_in/flush) or hold (pipe_hold). flush beats stall_in; pipe_hold beats both.
//  - Tag flags: LD sets [6], LDR sets [5]; ALU-result sets neither. Both never set together.
//  - Advance (no hold): ALU->MEM and MEM->WB each cycle; MEMout<=alu_result for ALU-result
//    entries, WBout<=MEMout. 1 cycle latency per stage; rf write occurs in cycle entry is in WB.
//  - rf_we = WB entry valid and rc!=ZERO_R; asserted exactly once per entry. rf_wa=aP2[4:0], rf_wd=WBout.
//  - MEM FSM: IDLE -> WAIT when LD/LDR entry arrives in MEM. WAIT: pipe_hold=1, aP1 flags kept.
//    On mem_rvalid in WAIT: MEMout<=mem_rdata, aP1 flags cleared, -> DONE. DONE: pipe_hold=0,
//    entry advances next cycle -> IDLE (or WAIT if next entry is also a load).
//  - mem_rvalid outside WAIT is ignored. mem_rvalid on same cycle entry arrives is not accepted
//    (earliest capture = 1 cycle after arrival).
//  - During pipe_hold: ALU and MEM stages frozen; WB drains to bubble (no duplicate write);
//    alu_result of held ALU entry is re-sampled when advance resumes.
//  - Back-to-back loads: second load waits in ALU stage (aP0[6]=1) until first leaves MEM.
//  - rst mid-WAIT: FSM->IDLE, pending load discarded, no rf write.
// CONFIGURATION
//  BETA_LDR_EN defined: id_kind 10 is a load (sets [5], uses MEM FSM).
//  Not defined: id_kind 10 treated as ALU-result (no flags, no hold, data from alu_result).
// TESTING
//  1. ALU op rc=3, alu_result=0x11 -> aP0=0x03 c1, aP1=0x03 c2, rf_we c3 wa=3 wd=0x11.
//  2. LD rc=5, mem_rvalid 3 cycles after MEM entry, data 0xAB -> aP1=0x45, pipe_hold=1 for 3 cycles, then rf write 5<-0xAB once.
//  3. id_valid with stall_in=1 -> aP0=0x1F next cycle, no rf_we for that slot.
//  4. rc=31 ALU op, alu_result=0xFF -> rf_we never asserted.
//  5. rst asserted while in WAIT -> next cycle all tags 0x1F, pipe_hold=0, no write.
//  6. LDR rc=7: with BETA_LDR_EN aP1=0x27 and hold; without, aP1=0x07, no hold, wd=alu_result.

Source files
------------

// File: rtl/beta_dest_pipe.sv
// Destination-tag / result pipeline (ALU -> MEM -> WB) feeding the Beta bypass units, with the
// load-completion FSM that freezes the pipe. Optional LDR support: define BETA_LDR_EN.
module beta_dest_pipe #(
   parameter int         DW     = 32,
   parameter logic [4:0] ZERO_R = 5'd31
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [4:0]    id_rc,
   input  logic [1:0]    id_kind,
   input  logic          stall_in,
   input  logic          flush,
   input  logic [DW-1:0] alu_result,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_rvalid,
   output logic [6:0]    aP0,
   output logic [6:0]    aP1,
   output logic [6:0]    aP2,
   output logic [DW-1:0] ALUout,
   output logic [DW-1:0] MEMout,
   output logic [DW-1:0] WBout,
   output logic          rf_we,
   output logic [4:0]    rf_wa,
   output logic [DW-1:0] rf_wd,
   output logic          pipe_hold
);

   localparam logic [6:0] BUBBLE = {2'b00, ZERO_R};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic            hold_s;
   logic [6:0]      id_tag_s;
   logic [6:0]      a0_r;
   logic [6:0]      a1_r;
   logic [6:0]      a2_r;
   logic [DW-1:0]   mem_r;
   logic [DW-1:0]   wb_r;
   logic            we_r;

   // Translate the decoded instruction into a stage tag; no-write kinds look like bubbles.
   always_comb begin
      id_tag_s = BUBBLE;
      case (id_kind)
         2'b00:   id_tag_s = {2'b00, id_rc};
         2'b01:   id_tag_s = {2'b10, id_rc};
`ifdef BETA_LDR_EN
         2'b10:   id_tag_s = {2'b01, id_rc};
`else
         2'b10:   id_tag_s = {2'b00, id_rc};
`endif
         2'b11:   id_tag_s = BUBBLE;
         default: id_tag_s = BUBBLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Outside WAIT the pipe always advances, so a load in ALU is the one arriving in MEM.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_WAIT: begin
            if (mem_rvalid) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_IDLE, S_DONE: begin
            if (|a0_r[6:5]) begin
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   always_comb begin
      hold_s = 1'b0;
      case (state_r)
         S_WAIT:  hold_s = 1'b1;
         default: hold_s = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a0_r  <= BUBBLE;
         a1_r  <= BUBBLE;
         a2_r  <= BUBBLE;
         mem_r <= '0;
         wb_r  <= '0;
         we_r  <= 1'b0;
      end else if (hold_s) begin
         // ALU frozen; MEM frozen until load data lands; WB drains so nothing is written twice.
         a0_r <= a0_r;
         if (mem_rvalid) begin
            a1_r  <= {2'b00, a1_r[4:0]};
            mem_r <= mem_rdata;
         end else begin
            a1_r  <= a1_r;
            mem_r <= mem_r;
         end
         a2_r <= BUBBLE;
         wb_r <= wb_r;
         we_r <= 1'b0;
      end else begin
         if (flush || stall_in || !id_valid) begin
            a0_r <= BUBBLE;
         end else begin
            a0_r <= id_tag_s;
         end
         a1_r  <= a0_r;
         mem_r <= (|a0_r[6:5]) ? '0 : alu_result;
         a2_r  <= a1_r;
         wb_r  <= mem_r;
         we_r  <= (a1_r[4:0] != ZERO_R);
      end
   end

   assign aP0       = a0_r;
   assign aP1       = a1_r;
   assign aP2       = a2_r;
   assign ALUout    = alu_result;
   assign MEMout    = mem_r;
   assign WBout     = wb_r;
   assign rf_we     = we_r;
   assign rf_wa     = a2_r[4:0];
   assign rf_wd     = wb_r;
   assign pipe_hold = hold_s;

endmodule

// File: tb/tb_beta_dest_pipe.sv
// Directed self-checking bench for beta_dest_pipe; each scenario task checks its own vectors.
module tb_beta_dest_pipe;
   logic        clk = 1'b0;
   logic        rst, id_valid, stall_in, flush, mem_rvalid;
   logic [4:0]  id_rc;
   logic [1:0]  id_kind;
   logic [31:0] alu_result, mem_rdata;
   logic [6:0]  aP0, aP1, aP2;
   logic [31:0] ALUout, MEMout, WBout, rf_wd;
   logic        rf_we, pipe_hold;
   logic [4:0]  rf_wa;
   int          checks = 0;
   int          failures = 0;
   int          cnt;

   beta_dest_pipe dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rc(id_rc), .id_kind(id_kind),
      .stall_in(stall_in), .flush(flush), .alu_result(alu_result), .mem_rdata(mem_rdata),
      .mem_rvalid(mem_rvalid), .aP0(aP0), .aP1(aP1), .aP2(aP2), .ALUout(ALUout),
      .MEMout(MEMout), .WBout(WBout), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .pipe_hold(pipe_hold)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      id_valid = 1'b0; id_rc = 5'd0; id_kind = 2'b00; stall_in = 1'b0; flush = 1'b0;
      mem_rvalid = 1'b0; mem_rdata = 32'h0; alu_result = 32'h0;
   endtask

   task automatic drain();
      quiet();
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_reset();
      quiet(); rst = 1'b1; tick(); tick();
      checks++; if (aP0 !== 7'h1F || aP1 !== 7'h1F || aP2 !== 7'h1F) begin
         failures++; $display("FAIL reset_tags got=%h/%h/%h exp=1f", aP0, aP1, aP2); end
      checks++; if (MEMout !== 32'h0 || WBout !== 32'h0) begin
         failures++; $display("FAIL reset_data got=%h/%h exp=0", MEMout, WBout); end
      checks++; if (rf_we !== 1'b0 || pipe_hold !== 1'b0) begin
         failures++; $display("FAIL reset_ctl we=%b hold=%b exp=0/0", rf_we, pipe_hold); end
      rst = 1'b0;
   endtask

   task automatic test_alu();
      id_valid = 1'b1; id_rc = 5'd3; id_kind = 2'b00; tick();
      checks++; if (aP0 !== 7'h03) begin failures++; $display("FAIL alu_ap0 got=%h exp=03", aP0); end
      quiet(); alu_result = 32'h11;
      checks++; if (ALUout !== 32'h11) begin failures++; $display("FAIL alu_out got=%h exp=11", ALUout); end
      tick(); alu_result = 32'h0;
      checks++; if (aP1 !== 7'h03 || MEMout !== 32'h11) begin
         failures++; $display("FAIL alu_mem got=%h/%h exp=03/11", aP1, MEMout); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h11 || aP2 !== 7'h03) begin
         failures++; $display("FAIL alu_wb we=%b wa=%0d wd=%h exp=1/3/11", rf_we, rf_wa, rf_wd); end
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL alu_once we=%b exp=0", rf_we); end
      drain();
   endtask

   task automatic test_load();
      id_valid = 1'b1; id_rc = 5'd5; id_kind = 2'b01; tick();
      checks++; if (aP0 !== 7'h45) begin failures++; $display("FAIL ld_ap0 got=%h exp=45", aP0); end
      // rvalid in the arrival cycle must be ignored
      quiet(); mem_rvalid = 1'b1; mem_rdata = 32'hEE; tick();
      mem_rvalid = 1'b0;
      checks++; if (aP1 !== 7'h45 || pipe_hold !== 1'b1) begin
         failures++; $display("FAIL ld_wait got=%h hold=%b exp=45/1", aP1, pipe_hold); end
      cnt = 1;
      tick(); cnt += pipe_hold;
      tick(); cnt += pipe_hold;
      checks++; if (aP1 !== 7'h45 || rf_we !== 1'b0) begin
         failures++; $display("FAIL ld_held got=%h we=%b exp=45/0", aP1, rf_we); end
      mem_rvalid = 1'b1; mem_rdata = 32'hAB; tick(); cnt += pipe_hold;
      mem_rvalid = 1'b0;
      checks++; if (cnt !== 3) begin failures++; $display("FAIL ld_hold_len got=%0d exp=3", cnt); end
      checks++; if (aP1 !== 7'h05 || MEMout !== 32'hAB) begin
         failures++; $display("FAIL ld_done got=%h/%h exp=05/ab", aP1, MEMout); end
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rf_we === 1'b1) begin
            cnt++;
            checks++; if (rf_wa !== 5'd5 || rf_wd !== 32'hAB) begin
               failures++; $display("FAIL ld_wr wa=%0d wd=%h exp=5/ab", rf_wa, rf_wd); end
         end
      end
      checks++; if (cnt !== 1) begin failures++; $display("FAIL ld_wr_count got=%0d exp=1", cnt); end
      drain();
   endtask

   task automatic test_stall_flush();
      id_valid = 1'b1; id_rc = 5'd9; id_kind = 2'b00; stall_in = 1'b1; tick();
      checks++; if (aP0 !== 7'h1F) begin failures++; $display("FAIL stall_ap0 got=%h exp=1f", aP0); end
      stall_in = 1'b0; flush = 1'b1; tick();
      checks++; if (aP0 !== 7'h1F) begin failures++; $display("FAIL flush_ap0 got=%h exp=1f", aP0); end
      quiet(); cnt = 0;
      for (int i = 0; i < 4; i++) begin tick(); cnt += rf_we; end
      checks++; if (cnt !== 0) begin failures++; $display("FAIL stall_nowr got=%0d exp=0", cnt); end
   endtask

   task automatic test_zero_reg();
      id_valid = 1'b1; id_rc = 5'd31; id_kind = 2'b00; tick();
      quiet(); alu_result = 32'hFF; cnt = 0;
      for (int i = 0; i < 4; i++) begin tick(); cnt += rf_we; end
      checks++; if (cnt !== 0) begin failures++; $display("FAIL r31_nowr got=%0d exp=0", cnt); end
      id_valid = 1'b1; id_rc = 5'd6; id_kind = 2'b11; tick();
      checks++; if (aP0 !== 7'h1F) begin failures++; $display("FAIL nowrite_kind got=%h exp=1f", aP0); end
      drain();
   endtask

   task automatic test_resample();
      id_valid = 1'b1; id_rc = 5'd5; id_kind = 2'b01; tick();
      id_rc = 5'd8; id_kind = 2'b00; tick();
      quiet(); alu_result = 32'h99; mem_rvalid = 1'b1; mem_rdata = 32'h77;
      checks++; if (aP0 !== 7'h08 || pipe_hold !== 1'b1) begin
         failures++; $display("FAIL rs_hold got=%h hold=%b exp=08/1", aP0, pipe_hold); end
      tick();
      mem_rvalid = 1'b0; alu_result = 32'h22;
      checks++; if (pipe_hold !== 1'b0 || aP0 !== 7'h08 || MEMout !== 32'h77) begin
         failures++; $display("FAIL rs_done hold=%b ap0=%h mem=%h exp=0/08/77", pipe_hold, aP0, MEMout); end
      tick();
      checks++; if (aP1 !== 7'h08 || MEMout !== 32'h22) begin
         failures++; $display("FAIL rs_resample got=%h/%h exp=08/22", aP1, MEMout); end
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'h77) begin
         failures++; $display("FAIL rs_wr we=%b wa=%0d wd=%h exp=1/5/77", rf_we, rf_wa, rf_wd); end
      drain();
   endtask

   task automatic test_back_to_back();
      id_valid = 1'b1; id_rc = 5'd5; id_kind = 2'b01; tick();
      id_rc = 5'd6; tick();
      quiet(); tick();
      checks++; if (aP0 !== 7'h46 || aP1 !== 7'h45 || pipe_hold !== 1'b1) begin
         failures++; $display("FAIL b2b_wait got=%h/%h hold=%b exp=46/45/1", aP0, aP1, pipe_hold); end
      mem_rvalid = 1'b1; mem_rdata = 32'h55; tick();
      mem_rvalid = 1'b0; tick();
      checks++; if (aP1 !== 7'h46 || pipe_hold !== 1'b1 || rf_we !== 1'b1 || rf_wd !== 32'h55) begin
         failures++; $display("FAIL b2b_second got=%h hold=%b we=%b wd=%h exp=46/1/1/55",
                              aP1, pipe_hold, rf_we, rf_wd); end
      mem_rvalid = 1'b1; mem_rdata = 32'h66; tick();
      mem_rvalid = 1'b0;
      checks++; if (rf_we !== 1'b0 || pipe_hold !== 1'b0) begin
         failures++; $display("FAIL b2b_nodup we=%b hold=%b exp=0/0", rf_we, pipe_hold); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd6 || rf_wd !== 32'h66) begin
         failures++; $display("FAIL b2b_wr2 we=%b wa=%0d wd=%h exp=1/6/66", rf_we, rf_wa, rf_wd); end
      drain();
   endtask

   task automatic test_reset_wait();
      id_valid = 1'b1; id_rc = 5'd10; id_kind = 2'b01; tick();
      quiet(); tick(); tick();
      rst = 1'b1; tick(); rst = 1'b0;
      checks++; if (aP0 !== 7'h1F || aP1 !== 7'h1F || aP2 !== 7'h1F || pipe_hold !== 1'b0) begin
         failures++; $display("FAIL rstwait got=%h/%h/%h hold=%b exp=1f/0", aP0, aP1, aP2, pipe_hold); end
      mem_rvalid = 1'b1; mem_rdata = 32'hCC; cnt = rf_we;
      for (int i = 0; i < 4; i++) begin tick(); cnt += rf_we; end
      checks++; if (cnt !== 0) begin failures++; $display("FAIL rstwait_nowr got=%0d exp=0", cnt); end
      drain();
   endtask

   task automatic test_ldr();
      id_valid = 1'b1; id_rc = 5'd7; id_kind = 2'b10; tick();
      quiet(); alu_result = 32'h3C;
`ifdef BETA_LDR_EN
      checks++; if (aP0 !== 7'h27) begin failures++; $display("FAIL ldr_ap0 got=%h exp=27", aP0); end
      tick(); alu_result = 32'h0;
      checks++; if (aP1 !== 7'h27 || pipe_hold !== 1'b1) begin
         failures++; $display("FAIL ldr_wait got=%h hold=%b exp=27/1", aP1, pipe_hold); end
      mem_rvalid = 1'b1; mem_rdata = 32'h5A; tick(); mem_rvalid = 1'b0; tick();
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h5A) begin
         failures++; $display("FAIL ldr_wr we=%b wa=%0d wd=%h exp=1/7/5a", rf_we, rf_wa, rf_wd); end
`else
      checks++; if (aP0 !== 7'h07) begin failures++; $display("FAIL ldr_ap0 got=%h exp=07", aP0); end
      tick(); alu_result = 32'h0;
      checks++; if (aP1 !== 7'h07 || pipe_hold !== 1'b0) begin
         failures++; $display("FAIL ldr_mem got=%h hold=%b exp=07/0", aP1, pipe_hold); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h3C) begin
         failures++; $display("FAIL ldr_wr we=%b wa=%0d wd=%h exp=1/7/3c", rf_we, rf_wa, rf_wd); end
`endif
      drain();
   endtask

   initial begin
      rst = 1'b1;
      quiet();
      test_reset();
      test_alu();
      test_load();
      test_stall_flush();
      test_zero_reg();
      test_resample();
      test_back_to_back();
      test_reset_wait();
      test_ldr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
